// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - phased sequencer issuing ALU datapath strobes for logic/add/sub/mul/div ops
module alu_control_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic          abort,
  input  logic          div_zero,
  input  logic          q0,
  input  logic          q_prev,
  input  logic          a_msb,
  output logic [11:0]   ctrl,
  output logic [4:0]    phase,
  output logic [CW-1:0] iter,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FINAL} state_t;

  state_t        state, state_n;
  logic [4:0]    phase_n;
  logic [CW-1:0] iter_n;
  logic [2:0]    op_q, op_n;
  logic          done_n, err_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      phase <= 5'd0;
      iter  <= '0;
      op_q  <= 3'd0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      iter  <= iter_n;
      op_q  <= op_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    iter_n  = iter;
    op_n    = op_q;
    done_n  = 1'b0;
    err_n   = err;
    if (state == S_IDLE) begin
      if (start) begin
        // reserved op or divide-by-zero is rejected without touching the datapath
        if (op == 3'b111 || (op == 3'b110 && div_zero)) begin
          done_n = 1'b1;
          err_n  = 1'b1;
        end else begin
          state_n = S_LOAD;
          phase_n = 5'b00001;
          iter_n  = '0;
          op_n    = op;
          err_n   = 1'b0;
        end
      end
    end else if (abort) begin
      state_n = S_IDLE;
      phase_n = 5'd0;
      iter_n  = '0;
    end else if (phase[4]) begin
      phase_n = 5'b00001;
      case (state)
        S_LOAD: begin
          if (op_q == 3'b101 || op_q == 3'b110) begin
            state_n = S_ITER;
            iter_n  = '0;
          end else begin
            state_n = S_FINAL;
          end
        end
        S_ITER: begin
          if (iter == CW'(WIDTH - 1)) state_n = S_FINAL;
          else                        iter_n  = iter + CW'(1);
        end
        default: begin
          state_n = S_IDLE;
          phase_n = 5'd0;
          iter_n  = '0;
          done_n  = 1'b1;
        end
      endcase
    end else begin
      phase_n = {phase[3:0], 1'b0};
    end
  end

  logic is_l, is_i, is_f, is_m, is_d;

  always_comb begin
    is_l = (state == S_LOAD);
    is_i = (state == S_ITER);
    is_f = (state == S_FINAL);
    is_m = (op_q == 3'b101);
    is_d = (op_q == 3'b110);
    ctrl = 12'd0;
    ctrl[0]  = is_l & phase[0];
    ctrl[1]  = is_l & phase[1];
    ctrl[2]  = is_l & phase[2] & (op_q <= 3'b100);
    ctrl[3]  = (is_l & phase[2] & (op_q == 3'b100))
             | (is_i & phase[0] & is_m & q0 & ~q_prev)
             | (is_i & phase[1] & is_d & ~a_msb);
    ctrl[4]  = (is_i & phase[0] & is_m & ~q0 & q_prev)
             | (is_i & phase[1] & is_d & a_msb);
    ctrl[5]  = is_i & phase[1] & is_m;
    ctrl[6]  = is_i & phase[0] & is_d;
    ctrl[7]  = is_i & phase[2] & is_d & ~a_msb;
    ctrl[8]  = is_f & phase[0] & is_d & a_msb;
    ctrl[9]  = is_f & phase[1];
    ctrl[10] = is_f & phase[2];
    ctrl[11] = is_l & phase[3] & (op_q <= 3'b010);
  end

  assign busy = (state != S_IDLE);

endmodule
